// File: rtl/ahb2apb_bridge.sv
// rtl/ahb2apb_bridge.sv - single-clock AHB-to-APB bridge, two-cycle APB transfers over four 4 KB slots
module ahb2apb_bridge #(
    parameter int SLOT_LSB = 12
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic        PENABLE,
    output logic [3:0]  PSEL,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_paddr;
    logic        r_pwrite;
    logic [1:0]  r_slot;
    logic [3:0]  r_psel;
    logic        r_penable;
    logic        r_hreadyout;

    logic        w_req;
    logic [1:0]  w_slot;
    logic [31:0] w_prdata;
    logic        w_unused;

    assign w_req    = HSEL & HTRANS[1] & HREADY;
    assign w_slot   = HADDR[SLOT_LSB+1:SLOT_LSB];
    assign w_unused = ^{HSIZE, HTRANS[0]};

    // New requests are only taken when the bus can present one: from IDLE, or
    // from ACCESS for zero-gap back-to-back transfers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= ST_IDLE;
            r_paddr     <= 32'h0;
            r_pwrite    <= 1'b0;
            r_slot      <= 2'd0;
            r_psel      <= 4'b0000;
            r_penable   <= 1'b0;
            r_hreadyout <= 1'b1;
        end else begin
            case (r_state)
                ST_SETUP: begin
                    r_state     <= ST_ACCESS;
                    r_penable   <= 1'b1;
                    r_hreadyout <= 1'b1;
                end
                ST_IDLE, ST_ACCESS: begin
                    if (w_req) begin
                        r_state     <= ST_SETUP;
                        r_paddr     <= HADDR;
                        r_pwrite    <= HWRITE;
                        r_slot      <= w_slot;
                        r_psel      <= 4'b0001 << w_slot;
                        r_penable   <= 1'b0;
                        r_hreadyout <= 1'b0;
                    end else begin
                        r_state     <= ST_IDLE;
                        r_psel      <= 4'b0000;
                        r_penable   <= 1'b0;
                        r_hreadyout <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_psel      <= 4'b0000;
                    r_penable   <= 1'b0;
                    r_hreadyout <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_prdata = PRDATA0;
        case (r_slot)
            2'd0: w_prdata = PRDATA0;
            2'd1: w_prdata = PRDATA1;
            2'd2: w_prdata = PRDATA2;
            2'd3: w_prdata = PRDATA3;
            default: w_prdata = PRDATA0;
        endcase
    end

    // PENABLE is high only in ACCESS, so it doubles as the read-data gate.
    assign HRDATA    = r_penable ? w_prdata : 32'h0;
    assign HREADYOUT = r_hreadyout;
    assign HRESP     = 1'b0;
    assign PADDR     = r_paddr;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = HWDATA;
    assign PENABLE   = r_penable;
    assign PSEL      = r_psel;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// tb/tb_ahb2apb_bridge.sv - self-checking bench for ahb2apb_bridge with a transfer-level reference model
module tb_ahb2apb_bridge;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        hready_en;
    wire         HREADY;
    wire         HREADYOUT;
    wire  [31:0] HRDATA;
    wire         HRESP;
    wire  [31:0] PADDR;
    wire         PWRITE;
    wire  [31:0] PWDATA;
    wire         PENABLE;
    wire  [3:0]  PSEL;
    logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;

    int n_tests = 0;
    int n_fail  = 0;

    // Single-slave system: the bus HREADY is the bridge's own HREADYOUT, optionally masked.
    assign HREADY = HREADYOUT & hready_en;

    // {PSEL, PENABLE, HREADYOUT, HRESP}
    wire [6:0] stat = {PSEL, PENABLE, HREADYOUT, HRESP};

    ahb2apb_bridge #(.SLOT_LSB(12)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL(PSEL),
        .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PRDATA3(PRDATA3)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    // Inputs change on the falling edge; outputs are checked 1 time unit later.
    task automatic cyc();
        @(negedge PCLK);
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic wr, input logic [2:0] size);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size;
    endtask

    task automatic drive_none();
        HSEL = 1'b0; HTRANS = 2'b00;
    endtask

    task automatic test_reset();
        #1;
        n_tests++; if (stat !== 7'b0000_0_1_0) begin n_fail++; $display("FAIL reset_stat: got %b want %b", stat, 7'b0000_0_1_0); end
        n_tests++; if ({PADDR, PWRITE} !== 33'h0) begin n_fail++; $display("FAIL reset_paddr_pwrite: got %h/%b want 0/0", PADDR, PWRITE); end
        n_tests++; if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata: got %h want 0", HRDATA); end
        cyc(); cyc(); #1;
        n_tests++; if (stat !== 7'b0000_0_1_0) begin n_fail++; $display("FAIL reset_held_stat: got %b want %b", stat, 7'b0000_0_1_0); end
        PRESETn = 1'b1;
    endtask

    task automatic test_write();
        drive_req(32'h4010_000C, 1'b1, 3'd2);
        cyc(); drive_none(); HWDATA = 32'h0000_0005; #1;
        n_tests++; if (stat !== 7'b0001_0_0_0) begin n_fail++; $display("FAIL write_t1_stat: got %b want %b", stat, 7'b0001_0_0_0); end
        n_tests++; if ({PADDR, PWRITE, PWDATA} !== {32'h4010_000C, 1'b1, 32'h5}) begin n_fail++; $display("FAIL write_t1_apb: got %h/%b/%h want 4010000c/1/5", PADDR, PWRITE, PWDATA); end
        cyc(); #1;
        n_tests++; if (stat !== 7'b0001_1_1_0) begin n_fail++; $display("FAIL write_t2_stat: got %b want %b", stat, 7'b0001_1_1_0); end
        cyc(); #1;
        n_tests++; if (stat !== 7'b0000_0_1_0) begin n_fail++; $display("FAIL write_t3_stat: got %b want %b", stat, 7'b0000_0_1_0); end
        n_tests++; if ({PADDR, PWRITE} !== {32'h4010_000C, 1'b1}) begin n_fail++; $display("FAIL write_t3_hold: got %h/%b want 4010000c/1", PADDR, PWRITE); end
    endtask

    task automatic test_read();
        PRDATA0 = 32'h1111_0000; PRDATA1 = 32'hA5A5_0003; PRDATA2 = 32'h2222_0000; PRDATA3 = 32'h3333_0000;
        drive_req(32'h4010_1004, 1'b0, 3'd2);
        cyc(); drive_none(); #1;
        n_tests++; if (stat !== 7'b0010_0_0_0) begin n_fail++; $display("FAIL read_t1_stat: got %b want %b", stat, 7'b0010_0_0_0); end
        n_tests++; if ({PADDR, PWRITE, HRDATA} !== {32'h4010_1004, 1'b0, 32'h0}) begin n_fail++; $display("FAIL read_t1_apb: got %h/%b/%h want 40101004/0/0", PADDR, PWRITE, HRDATA); end
        cyc(); #1;
        n_tests++; if (stat !== 7'b0010_1_1_0) begin n_fail++; $display("FAIL read_t2_stat: got %b want %b", stat, 7'b0010_1_1_0); end
        n_tests++; if (HRDATA !== 32'hA5A5_0003) begin n_fail++; $display("FAIL read_t2_hrdata: got %h want a5a50003", HRDATA); end
        cyc(); #1;
        n_tests++; if ({stat, HRDATA} !== {7'b0000_0_1_0, 32'h0}) begin n_fail++; $display("FAIL read_t3_idle: got %b/%h want 0000010/0", stat, HRDATA); end
    endtask

    task automatic test_back_to_back();
        PRDATA0 = 32'hC0DE_0008;
        drive_req(32'h4010_0004, 1'b1, 3'd2);
        cyc(); drive_none(); HWDATA = 32'h1234_5678; #1;
        n_tests++; if ({stat, PADDR} !== {7'b0001_0_0_0, 32'h4010_0004}) begin n_fail++; $display("FAIL b2b_setup1: got %b/%h want 0001000/40100004", stat, PADDR); end
        cyc(); drive_req(32'h4010_0008, 1'b0, 3'd2); #1;
        n_tests++; if ({stat, PADDR, PWDATA} !== {7'b0001_1_1_0, 32'h4010_0004, 32'h1234_5678}) begin n_fail++; $display("FAIL b2b_access1: got %b/%h/%h want 0001110/40100004/12345678", stat, PADDR, PWDATA); end
        cyc(); drive_none(); #1;
        n_tests++; if ({stat, PADDR, PWRITE} !== {7'b0001_0_0_0, 32'h4010_0008, 1'b0}) begin n_fail++; $display("FAIL b2b_setup2: got %b/%h/%b want 0001000/40100008/0", stat, PADDR, PWRITE); end
        cyc(); #1;
        n_tests++; if ({stat, HRDATA} !== {7'b0001_1_1_0, 32'hC0DE_0008}) begin n_fail++; $display("FAIL b2b_access2: got %b/%h want 0001110/c0de0008", stat, HRDATA); end
        cyc(); #1;
        n_tests++; if (stat !== 7'b0000_0_1_0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0000010", stat); end
    endtask

    task automatic test_ignored();
        HSEL = 1'b1; HTRANS = 2'b00; HADDR = 32'h4010_2000; HWRITE = 1'b1;
        cyc(); #1;
        n_tests++; if (stat !== 7'b0000_0_1_0) begin n_fail++; $display("FAIL ign_htrans_idle: got %b want 0000010", stat); end
        HTRANS = 2'b01;
        cyc(); #1;
        n_tests++; if (stat !== 7'b0000_0_1_0) begin n_fail++; $display("FAIL ign_htrans_busy: got %b want 0000010", stat); end
        HSEL = 1'b0; HTRANS = 2'b10;
        cyc(); #1;
        n_tests++; if (stat !== 7'b0000_0_1_0) begin n_fail++; $display("FAIL ign_hsel0: got %b want 0000010", stat); end
        HSEL = 1'b1; hready_en = 1'b0;
        cyc(); #1;
        n_tests++; if (stat !== 7'b0000_0_1_0) begin n_fail++; $display("FAIL ign_hready0: got %b want 0000010", stat); end
        hready_en = 1'b1; drive_none();
        cyc(); #1;
        n_tests++; if ({stat, PADDR} !== {7'b0000_0_1_0, 32'h4010_0008}) begin n_fail++; $display("FAIL ign_after: got %b/%h want 0000010/40100008", stat, PADDR); end
    endtask

    task automatic test_reset_in_access();
        drive_req(32'h4010_2010, 1'b1, 3'd2);
        cyc(); drive_none(); HWDATA = 32'h0BAD_0BAD;
        cyc(); #1;
        n_tests++; if (stat !== 7'b0100_1_1_0) begin n_fail++; $display("FAIL rst_acc_pre: got %b want 0100110", stat); end
        PRESETn = 1'b0; #1;
        n_tests++; if ({stat, PADDR, PWRITE, HRDATA} !== {7'b0000_0_1_0, 32'h0, 1'b0, 32'h0}) begin n_fail++; $display("FAIL rst_acc_async: got %b/%h/%b/%h want 0000010/0/0/0", stat, PADDR, PWRITE, HRDATA); end
        cyc(); PRESETn = 1'b1;
        drive_req(32'h4010_0020, 1'b1, 3'd2);
        cyc(); drive_none(); HWDATA = 32'h0000_00AA; #1;
        n_tests++; if ({stat, PADDR, PWDATA} !== {7'b0001_0_0_0, 32'h4010_0020, 32'hAA}) begin n_fail++; $display("FAIL rst_acc_post_setup: got %b/%h/%h want 0001000/40100020/aa", stat, PADDR, PWDATA); end
        cyc(); #1;
        n_tests++; if (stat !== 7'b0001_1_1_0) begin n_fail++; $display("FAIL rst_acc_post_access: got %b want 0001110", stat); end
        cyc(); #1;
    endtask

    task automatic test_byte_write();
        drive_req(32'h4010_3000, 1'b1, 3'd0);
        cyc(); drive_none(); HWDATA = 32'hDEAD_BEEF; #1;
        n_tests++; if ({stat, PADDR, PWRITE, PWDATA} !== {7'b1000_0_0_0, 32'h4010_3000, 1'b1, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL byte_setup: got %b/%h/%b/%h want 1000000/40103000/1/deadbeef", stat, PADDR, PWRITE, PWDATA); end
        cyc(); #1;
        n_tests++; if ({stat, PWDATA} !== {7'b1000_1_1_0, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL byte_access: got %b/%h want 1000110/deadbeef", stat, PWDATA); end
        cyc(); #1;
        n_tests++; if (stat !== 7'b0000_0_1_0) begin n_fail++; $display("FAIL byte_idle: got %b want 0000010", stat); end
    endtask

    // Reference model: each transfer is one SETUP and one ACCESS cycle on slave addr[13:12];
    // a zero gap issues the next address during ACCESS, otherwise the bus idles 'gap' cycles.
    task automatic test_random();
        logic [31:0] prd [4];
        logic [31:0] addr, wd, n_addr, n_wd;
        logic        wr, n_wr;
        logic [3:0]  exp_psel;
        int          gap;
        n_addr = 32'h4010_0000 | (32'($urandom_range(0, 3)) << 12) | ($urandom & 32'h0000_0FFC);
        n_wr = 1'($urandom); n_wd = $urandom;
        drive_req(n_addr, n_wr, 3'($urandom_range(0, 2)));
        for (int i = 0; i < 40; i++) begin
            addr = n_addr; wr = n_wr; wd = n_wd;
            exp_psel = 4'(1 << addr[13:12]);
            gap = (i == 39) ? 1 : $urandom_range(0, 2);
            for (int s = 0; s < 4; s++) prd[s] = $urandom;
            cyc(); drive_none(); HWDATA = wr ? wd : $urandom;
            PRDATA0 = prd[0]; PRDATA1 = prd[1]; PRDATA2 = prd[2]; PRDATA3 = prd[3]; #1;
            n_tests++; if ({stat, PADDR, PWRITE, HRDATA} !== {exp_psel, 3'b000, addr, wr, 32'h0}) begin n_fail++; $display("FAIL rnd_setup[%0d]: got %b/%h/%b/%h want %b000/%h/%b/0", i, stat, PADDR, PWRITE, HRDATA, exp_psel, addr, wr); end
            if (wr) begin
                n_tests++; if (PWDATA !== wd) begin n_fail++; $display("FAIL rnd_pwdata[%0d]: got %h want %h", i, PWDATA, wd); end
            end
            cyc();
            n_addr = 32'h4010_0000 | (32'($urandom_range(0, 3)) << 12) | ($urandom & 32'h0000_0FFC);
            n_wr = 1'($urandom); n_wd = $urandom;
            if (gap == 0) drive_req(n_addr, n_wr, 3'($urandom_range(0, 2)));
            #1;
            n_tests++; if ({stat, PADDR, HRDATA} !== {exp_psel, 3'b110, addr, prd[addr[13:12]]}) begin n_fail++; $display("FAIL rnd_access[%0d]: got %b/%h/%h want %b110/%h/%h", i, stat, PADDR, HRDATA, exp_psel, addr, prd[addr[13:12]]); end
            for (int g = 0; g < gap; g++) begin
                cyc(); #1;
                n_tests++; if ({stat, PADDR, PWRITE, HRDATA} !== {7'b0000_0_1_0, addr, wr, 32'h0}) begin n_fail++; $display("FAIL rnd_idle[%0d]: got %b/%h/%b/%h want 0000010/%h/%b/0", i, stat, PADDR, PWRITE, HRDATA, addr, wr); end
                if (g == gap - 1 && i != 39) drive_req(n_addr, n_wr, 3'($urandom_range(0, 2)));
            end
        end
    endtask

    initial begin
        PRESETn = 1'b1; hready_en = 1'b1;
        HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd2; HWDATA = 32'h0;
        PRDATA0 = 32'h0; PRDATA1 = 32'h0; PRDATA2 = 32'h0; PRDATA3 = 32'h0;
        #3 PRESETn = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_ignored();
        test_reset_in_access();
        test_byte_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb2apb_bridge.md
AHB2APB_BRIDGE -- requirements
Module: ahb2apb_bridge

Interface
REQ-001 Parameter SLOT_LSB, default 12, is the HADDR bit index of the 2-bit APB slave-slot field (4 KB slots).
REQ-002 PCLK  input  1  clock; AHB and APB sides both run on PCLK.
REQ-003 PRESETn  input  1  reset, asynchronous, active-low.
REQ-004 HSEL  input  1  AHB slave select for the APB region.
REQ-005 HADDR  input  32  AHB address.
REQ-006 HTRANS  input  2  AHB transfer type; NONSEQ=2'b10, SEQ=2'b11.
REQ-007 HWRITE  input  1  AHB direction, 1=write.
REQ-008 HSIZE  input  3  AHB size; ignored, every access is treated as a 32-bit word.
REQ-009 HWDATA  input  32  AHB write data.
REQ-010 HREADY  input  1  AHB bus ready.
REQ-011 HREADYOUT  output  1  bridge ready.
REQ-012 HRDATA  output  32  read data.
REQ-013 HRESP  output  1  response; tied 0 (OKAY).
REQ-014 PADDR  output  32  APB address.
REQ-015 PWRITE  output  1  APB direction.
REQ-016 PWDATA  output  32  APB write data.
REQ-017 PENABLE  output  1  APB access-phase strobe.
REQ-018 PSEL  output  4  one-hot APB slave selects; bit n = slot n; slot 0 = timer at 0x4010_0000.
REQ-019 PRDATA0..PRDATA3  input  32 each  per-slave read data.

Function
REQ-020 FSM states: IDLE, SETUP, ACCESS; no PREADY, so every APB transfer is exactly one SETUP cycle plus one ACCESS cycle.
REQ-021 Valid request = HSEL & HTRANS[1] & HREADY, sampled on the rising PCLK edge; BUSY and IDLE HTRANS are ignored and get zero-wait OKAY.
REQ-022 On a valid request: latch PADDR<=HADDR, PWRITE<=HWRITE, slot<=HADDR[SLOT_LSB+1:SLOT_LSB]; next state SETUP.
REQ-023 SETUP: PSEL[slot]=1, other PSEL bits 0, PENABLE=0, HREADYOUT=0; next state ACCESS unconditionally.
REQ-024 ACCESS: PSEL[slot]=1, PENABLE=1, HREADYOUT=1; the transfer completes at the end of this cycle.
REQ-025 From ACCESS, a valid request in the same cycle goes directly to SETUP with new latches (back-to-back, 2 cycles per transfer); otherwise the next state is IDLE.
REQ-026 IDLE: PSEL=0, PENABLE=0, HREADYOUT=1; PADDR and PWRITE hold their last values.
REQ-027 PWDATA is combinational HWDATA; the AHB master holds HWDATA stable through the stalled data phase, so it is valid during SETUP and ACCESS.
REQ-028 HRDATA is combinational PRDATA[slot] during ACCESS and 32'h0 otherwise; it is only meaningful in ACCESS of a read.
REQ-029 Read timing is compatible with slaves that register PRDATA on the setup phase (PSEL & !PENABLE): data is valid in ACCESS.
REQ-030 PSEL and PENABLE are registered outputs, glitch-free; PSEL never has more than one bit set.
REQ-031 Total latency from address phase to completion is 2 cycles; HREADYOUT is low for exactly 1 cycle per transfer.

Reset
REQ-032 Asynchronous assertion of PRESETn forces IDLE, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, slot=0, HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-033 Reset asserted in SETUP or ACCESS aborts the transfer with no APB access completion; after release the bridge is in IDLE and accepts a new request on the first edge.

Verification
REQ-034 Write 0x0000_0005 to 0x4010_000C -> T1: PSEL=4'b0001, PENABLE=0, PADDR=0x4010_000C, PWRITE=1, PWDATA=5, HREADYOUT=0; T2: PENABLE=1, HREADYOUT=1; T3: IDLE.
REQ-035 Read 0x4010_1004 with PRDATA1=0xA5A5_0003 -> PSEL=4'b0010 in T1/T2; in T2 HRDATA=0xA5A5_0003 and HREADYOUT=1.
REQ-036 Back-to-back: write 0x4010_0004 then read 0x4010_0008 pipelined -> SETUP/ACCESS/SETUP/ACCESS with no IDLE cycle between; PADDR changes at the second SETUP.
REQ-037 HTRANS=IDLE with HSEL=1, and HTRANS=NONSEQ with HSEL=0 -> PSEL stays 0, HREADYOUT stays 1, FSM stays IDLE.
REQ-038 PRESETn pulsed low during ACCESS -> PSEL=0, PENABLE=0, and HREADYOUT=1 immediately (asynchronous); a subsequent write completes normally.
REQ-039 A write with HSIZE=byte to 0x4010_3000 -> full-word APB write on PSEL=4'b1000, and HRESP stays 0 throughout.
